// File: rtl/pht_update_scheduler.sv
// PHT write scheduler: runs the post-reset init sweep, then drains an in-order
// queue of resolved-branch counter updates onto bank-conflict-free write ports.
module pht_update_scheduler #(
  parameter int ENTRY_NUM   = 2048,
  parameter int ENTRY_WIDTH = 2,
  parameter int BANK_NUM    = 2,
  parameter int REQ_NUM     = 2,
  parameter int WRITE_NUM   = 2,
  parameter int QUEUE_DEPTH = 8,
  parameter int INIT_VALUE  = 2,
  localparam int INDEX_W    = $clog2(ENTRY_NUM),
  localparam int CNT_W      = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [REQ_NUM-1:0]                      updValid,
  input  logic [REQ_NUM-1:0][INDEX_W-1:0]         updIndex,
  input  logic [REQ_NUM-1:0][ENTRY_WIDTH-1:0]     updValue,
  output logic                                    ready,
  output logic [WRITE_NUM-1:0]                    phtWE,
  output logic [WRITE_NUM-1:0][INDEX_W-1:0]       phtWA,
  output logic [WRITE_NUM-1:0][ENTRY_WIDTH-1:0]   phtWV,
  output logic                                    initDone,
  output logic [CNT_W-1:0]                        queueCount,
  output logic [15:0]                             dropCount,
  output logic                                    dbg_state
);

  localparam int PTR_W  = $clog2(QUEUE_DEPTH);
  localparam int REQ_CW = $clog2(REQ_NUM + 1);
  localparam logic [INDEX_W-1:0] BANK_MASK = INDEX_W'(BANK_NUM - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                 state_q, state_d;
  logic [INDEX_W-1:0]     init_idx_q, init_idx_d;
  logic [INDEX_W-1:0]     q_idx_q [QUEUE_DEPTH];
  logic [INDEX_W-1:0]     q_idx_d [QUEUE_DEPTH];
  logic [ENTRY_WIDTH-1:0] q_val_q [QUEUE_DEPTH];
  logic [ENTRY_WIDTH-1:0] q_val_d [QUEUE_DEPTH];
  logic [PTR_W-1:0]       head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [15:0]            drop_q, drop_d;

  logic [CNT_W-1:0]       n_enq, n_deq;
  logic [REQ_CW-1:0]      n_drop;
  logic [16:0]            drop_sum;
  logic                   blocked, conflict;
  logic [PTR_W-1:0]       rd_ptr, cmp_ptr, wr_ptr;

  // ready and initDone are forced low while rst is high, whatever the state.
  assign initDone   = !rst && (state_q == ST_RUN);
  assign ready      = initDone && (count_q <= CNT_W'(QUEUE_DEPTH - REQ_NUM));
  assign queueCount = count_q;
  assign dropCount  = drop_q;
  assign dbg_state  = (state_q == ST_RUN);

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    case (state_q)
      ST_INIT: begin
        init_idx_d = init_idx_q + INDEX_W'(1);
        if (init_idx_q == INDEX_W'(ENTRY_NUM - 1)) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Write ports: port k takes head+k only while every lower port issued and
  // no entry already issued this cycle sits in the same bank.
  always_comb begin
    phtWE   = '0;
    phtWA   = '0;
    phtWV   = '0;
    n_deq   = '0;
    rd_ptr  = '0;
    cmp_ptr = '0;
    conflict = 1'b0;
    blocked = rst || (state_q != ST_RUN);
    if (!rst && state_q == ST_INIT) begin
      phtWE[0] = 1'b1;
      phtWA[0] = init_idx_q;
      phtWV[0] = ENTRY_WIDTH'(INIT_VALUE);
    end
    for (int k = 0; k < WRITE_NUM; k++) begin
      rd_ptr   = head_q + PTR_W'(k);
      conflict = 1'b0;
      for (int j = 0; j < k; j++) begin
        cmp_ptr = head_q + PTR_W'(j);
        if ((q_idx_q[cmp_ptr] & BANK_MASK) == (q_idx_q[rd_ptr] & BANK_MASK)) conflict = 1'b1;
      end
      if (!blocked && (CNT_W'(k) < count_q) && !conflict) begin
        phtWE[k] = 1'b1;
        phtWA[k] = q_idx_q[rd_ptr];
        phtWV[k] = q_val_q[rd_ptr];
        n_deq    = n_deq + CNT_W'(1);
      end else begin
        blocked = 1'b1;
      end
    end
  end

  // Enqueue compacts valid ports into consecutive tail slots.
  always_comb begin
    q_idx_d = q_idx_q;
    q_val_d = q_val_q;
    n_enq   = '0;
    n_drop  = '0;
    wr_ptr  = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (updValid[i]) begin
        if (ready) begin
          wr_ptr          = tail_q + PTR_W'(n_enq);
          q_idx_d[wr_ptr] = updIndex[i];
          q_val_d[wr_ptr] = updValue[i];
          n_enq           = n_enq + CNT_W'(1);
        end else begin
          n_drop = n_drop + REQ_CW'(1);
        end
      end
    end
    tail_d   = tail_q + PTR_W'(n_enq);
    head_d   = head_q + PTR_W'(n_deq);
    count_d  = count_q + n_enq - n_deq;
    drop_sum = {1'b0, drop_q} + 17'(n_drop);
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_idx_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      drop_q     <= drop_d;
    end
  end

  // Queue payload needs no reset: occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    q_idx_q <= q_idx_d;
    q_val_q <= q_val_d;
  end

endmodule

// File: tb/tb_pht_update_scheduler.sv
// Randomized bench for pht_update_scheduler with a queue-level reference model
// and a write-port monitor that pops an expected-write scoreboard.
module tb_pht_update_scheduler;
  localparam int EN = 16;
  localparam int EW = 2;
  localparam int BN = 2;
  localparam int RN = 2;
  localparam int WN = 2;
  localparam int QD = 8;
  localparam int IV = 2;
  localparam int IW = 4;
  localparam int CW = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [RN-1:0]          upd_valid = '0;
  logic [RN-1:0][IW-1:0]  upd_index = '0;
  logic [RN-1:0][EW-1:0]  upd_value = '0;
  logic                   ready;
  logic [WN-1:0]          pht_we;
  logic [WN-1:0][IW-1:0]  pht_wa;
  logic [WN-1:0][EW-1:0]  pht_wv;
  logic                   init_done;
  logic [CW-1:0]          queue_count;
  logic [15:0]            drop_count;
  logic                   dbg_state;

  pht_update_scheduler #(
    .ENTRY_NUM(EN), .ENTRY_WIDTH(EW), .BANK_NUM(BN), .REQ_NUM(RN),
    .WRITE_NUM(WN), .QUEUE_DEPTH(QD), .INIT_VALUE(IV)
  ) dut (
    .clk(clk), .rst(rst),
    .updValid(upd_valid), .updIndex(upd_index), .updValue(upd_value),
    .ready(ready), .phtWE(pht_we), .phtWA(pht_wa), .phtWV(pht_wv),
    .initDone(init_done), .queueCount(queue_count), .dropCount(drop_count),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // scoreboard: expected RUN-mode writes {index, value} in enqueue order
  logic [IW+EW-1:0] exp_q[$];
  // reference model state
  logic [IW+EW-1:0] pend_q[$];
  int mdl_cyc  = 0;
  int mdl_drop = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // One clock cycle: drive inputs, check this cycle's outputs, advance model.
  task automatic step(input logic r, input logic [RN-1:0] v,
                      input logic [RN-1:0][IW-1:0] idx, input logic [RN-1:0][EW-1:0] val);
    int n_deq;
    int b;
    logic [BN-1:0] used;
    bit exp_ready;
    rst = r;
    upd_valid = v;
    upd_index = idx;
    upd_value = val;
    #1;
    if (r) begin
      check("rst_we", 32'(pht_we), 0);
      check("rst_ready", 32'(ready), 0);
      check("rst_init_done", 32'(init_done), 0);
      pend_q.delete();
      exp_q.delete();
      mdl_drop = 0;
      mdl_cyc  = 0;
    end else if (mdl_cyc < EN) begin
      check("init_done_low", 32'(init_done), 0);
      check("init_ready", 32'(ready), 0);
      check("init_we", 32'(pht_we), 1);
      check("init_wa", 32'(pht_wa[0]), 32'(mdl_cyc));
      check("init_wv", 32'(pht_wv[0]), IV);
      check("init_qcount", 32'(queue_count), 0);
      check("init_drop", 32'(drop_count), 32'(mdl_drop));
      mdl_drop = mdl_drop + $countones(v);
      if (mdl_drop > 16'hFFFF) mdl_drop = 16'hFFFF;
      mdl_cyc++;
    end else begin
      exp_ready = (pend_q.size() <= QD - RN);
      check("run_init_done", 32'(init_done), 1);
      check("run_ready", 32'(ready), 32'(exp_ready));
      check("run_qcount", 32'(queue_count), 32'(pend_q.size()));
      check("run_drop", 32'(drop_count), 32'(mdl_drop));
      n_deq = 0;
      used  = '0;
      while (n_deq < WN && pend_q.size() > 0) begin
        b = int'(pend_q[0][IW+EW-1:EW]) % BN;
        if (used[b]) break;
        used[b] = 1'b1;
        void'(pend_q.pop_front());
        n_deq++;
      end
      check("write_count", 32'($countones(pht_we)), 32'(n_deq));
      for (int p = 0; p < RN; p++) begin
        if (v[p]) begin
          if (exp_ready) begin
            pend_q.push_back({idx[p], val[p]});
            exp_q.push_back({idx[p], val[p]});
          end else begin
            mdl_drop++;
          end
        end
      end
      if (mdl_drop > 16'hFFFF) mdl_drop = 16'hFFFF;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0);
  endtask

  task automatic rand_step(input logic r, input bit same_bank);
    logic [RN-1:0] v;
    logic [RN-1:0][IW-1:0] idx;
    logic [RN-1:0][EW-1:0] val;
    v = same_bank ? '1 : RN'($urandom_range(0, (1 << RN) - 1));
    for (int p = 0; p < RN; p++) begin
      idx[p] = IW'($urandom_range(0, EN - 1));
      if (same_bank) idx[p][0] = 1'b0;
      val[p] = EW'($urandom_range(0, (1 << EW) - 1));
    end
    step(r, v, idx, val);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (pend_q.size() > 0 && guard < 50) begin
      idle(1);
      guard++;
    end
    check("drain_model_empty", 32'(pend_q.size()), 0);
    idle(1);
    check("drain_scoreboard_empty", 32'(exp_q.size()), 0);
  endtask

  // monitor: every RUN-mode write must match the oldest outstanding update
  always @(negedge clk) begin : monitor
    logic [IW+EW-1:0] e;
    if (init_done) begin
      for (int k = 0; k < WN; k++) begin
        if (pht_we[k]) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: port %0d index %0d value %0d, expected none at %0t",
                     k, pht_wa[k], pht_wv[k], $time);
          end else begin
            e = exp_q.pop_front();
            check("write_index", 32'(pht_wa[k]), 32'(e[IW+EW-1:EW]));
            check("write_value", 32'(pht_wv[k]), 32'(e[EW-1:0]));
          end
        end
      end
    end
  end

  initial begin
    int guard;
    @(posedge clk);
    #1;
    // reset with traffic: nothing counted
    rand_step(1'b1, 1'b0);
    rand_step(1'b1, 1'b1);
    // init sweep with random traffic that must all be dropped
    for (int i = 0; i < EN; i++) rand_step(1'b0, 1'b0);
    idle(2);
    // single update
    step(1'b0, 2'b01, {4'd0, 4'd5}, {2'd0, 2'd3});
    idle(3);
    // different-bank pair
    step(1'b0, 2'b11, {4'd7, 4'd4}, {2'd1, 2'd2});
    idle(2);
    // same-bank pair
    step(1'b0, 2'b11, {4'd6, 4'd4}, {2'd3, 2'd0});
    idle(3);
    // sustained same-bank pairs to overflow
    for (int i = 0; i < 12; i++) rand_step(1'b0, 1'b1);
    drain();
    // random traffic
    for (int i = 0; i < 300; i++) rand_step(1'b0, ($urandom_range(0, 3) == 0));
    drain();
    // reset with five updates queued
    guard = 0;
    while (pend_q.size() < 5 && guard < 20) begin
      rand_step(1'b0, 1'b1);
      guard++;
    end
    check("pre_reset_qcount", 32'(queue_count), 5);
    rand_step(1'b1, 1'b0);
    for (int i = 0; i < EN; i++) idle(1);
    idle(10);
    for (int i = 0; i < 100; i++) rand_step(1'b0, 1'b0);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
